// File: rtl/matmul_scheduler.sv
// Round-robin scheduler sharing one 4x4 Q8.8 matrix-vector multiplier between NREQ requesters.
// Optional per-requester completion counters are enabled with `define MATMUL_SCHED_STATS_EN.
module matmul_scheduler #(
   parameter int NREQ   = 2,
   parameter int NBANKS = 2,
   parameter int LAT    = 1,
   localparam int BW    = (NBANKS > 1) ? $clog2(NBANKS) : 1,
   localparam int GW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                           Clk,
   input  logic                           Reset,
   input  logic                           cfg_we,
   input  logic [BW-1:0]                  cfg_bank,
   input  logic [3:0]                     cfg_idx,
   input  logic [15:0]                    cfg_data,
   input  logic [NREQ-1:0]                req_valid,
   output logic [NREQ-1:0]                req_ready,
   input  logic [NREQ-1:0][BW-1:0]        req_bank,
   input  logic [NREQ-1:0][3:0][15:0]     req_vec,
   output logic [NREQ-1:0]                rsp_valid,
   input  logic [NREQ-1:0]                rsp_ready,
   output logic [3:0][15:0]               rsp_vec,
   output logic                           busy,
   output logic [3:0][15:0]               mm_ivector,
   output logic [15:0][15:0]              mm_matrix,
   input  logic [3:0][15:0]               mm_ovector,
`ifdef MATMUL_SCHED_STATS_EN
   output logic [NREQ-1:0][31:0]          stat_ops,
`endif
   output logic [1:0]                     state_dbg
);

   localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_RESP  = 2'd2;

   logic [1:0]                     state;
   logic [GW-1:0]                  last_grant;
   logic [GW-1:0]                  grant_idx;
   logic                           grant_found;
   logic [CW-1:0]                  lat_cnt;
   logic [NBANKS-1:0][15:0][15:0]  bank_mem;
   logic                           req_accept;
   logic                           resp_done;

   // Arbiter: first valid requester starting after the previous winner, with wrap.
   int            cand;
   logic [GW-1:0] cand_idx;
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      cand_idx    = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand = int'(last_grant) + 1 + i;
         if (cand >= NREQ) cand = cand - NREQ;
         cand_idx = GW'(cand);
         if (!grant_found && req_valid[cand_idx]) begin
            grant_found = 1'b1;
            grant_idx   = cand_idx;
         end
      end
   end

   // Handshakes: a transfer happens in a cycle where valid and ready are both high;
   // valid must not depend on ready, ready may depend on valid.
   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      rsp_vec   = '0;
      if (!Reset && state == S_IDLE && grant_found) req_ready[grant_idx] = 1'b1;
      if (state == S_RESP) begin
         rsp_valid[last_grant] = 1'b1;
         rsp_vec               = mm_ovector;
      end
   end

   assign req_accept = !Reset && state == S_IDLE && grant_found;
   assign resp_done  = state == S_RESP && rsp_ready[last_grant];
   assign busy       = state != S_IDLE;
   assign state_dbg  = state;

   // Bank storage resets to identity; writes land regardless of FSM state.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int b = 0; b < NBANKS; b++) begin
            for (int e = 0; e < 16; e++) begin
               bank_mem[b][e] <= (e % 5 == 0) ? 16'h0100 : 16'h0000;
            end
         end
      end else if (cfg_we) begin
         bank_mem[cfg_bank][cfg_idx] <= cfg_data;
      end
   end

   // The snapshot reads bank_mem before any same-cycle write lands.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state      <= S_IDLE;
         last_grant <= GW'(NREQ - 1);
         lat_cnt    <= '0;
         mm_ivector <= '0;
         mm_matrix  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_accept) begin
                  mm_ivector <= req_vec[grant_idx];
                  mm_matrix  <= bank_mem[req_bank[grant_idx]];
                  last_grant <= grant_idx;
                  lat_cnt    <= CW'(LAT - 1);
                  state      <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (lat_cnt == '0) state <= S_RESP;
               else               lat_cnt <= lat_cnt - CW'(1);
            end
            S_RESP: begin
               if (resp_done) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef MATMUL_SCHED_STATS_EN
   always_ff @(posedge Clk) begin
      if (Reset) begin
         stat_ops <= '0;
      end else if (resp_done && stat_ops[last_grant] != 32'hFFFF_FFFF) begin
         stat_ops[last_grant] <= stat_ops[last_grant] + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_matmul_scheduler.sv
// Directed bench for matmul_scheduler with a registered Q8.8 multiplier model (LAT=1).
module tb_matmul_scheduler;

   localparam int NREQ   = 2;
   localparam int NBANKS = 2;
   localparam int LAT    = 1;
   localparam int BW     = 1;

   typedef logic [3:0][15:0] vec_t;

   typedef struct {
      bit          wr_en;
      logic [0:0]  wr_bank;
      logic [3:0]  wr_idx;
      logic [15:0] wr_data;
      bit          op_en;
      int          r;
      logic [0:0]  bank;
      vec_t        vec;
      vec_t        exp;
   } rec_t;

   logic                       clk = 1'b0;
   logic                       reset = 1'b1;
   logic                       cfg_we = 1'b0;
   logic [BW-1:0]              cfg_bank = '0;
   logic [3:0]                 cfg_idx = '0;
   logic [15:0]                cfg_data = '0;
   logic [NREQ-1:0]            req_valid = '0;
   logic [NREQ-1:0]            req_ready;
   logic [NREQ-1:0][BW-1:0]    req_bank = '0;
   logic [NREQ-1:0][3:0][15:0] req_vec = '0;
   logic [NREQ-1:0]            rsp_valid;
   logic [NREQ-1:0]            rsp_ready = '0;
   vec_t                       rsp_vec;
   logic                       busy;
   vec_t                       mm_ivector;
   logic [15:0][15:0]          mm_matrix;
   vec_t                       mm_ovector = '0;
   logic [1:0]                 state_dbg;
`ifdef MATMUL_SCHED_STATS_EN
   logic [NREQ-1:0][31:0]      stat_ops;
`endif

   int          checks = 0;
   int          failures = 0;
   logic [63:0] exp_q[$];
   logic [63:0] rsp_q[$];
   rec_t        tbl[11];

   matmul_scheduler #(.NREQ(NREQ), .NBANKS(NBANKS), .LAT(LAT)) dut (
      .Clk(clk), .Reset(reset),
      .cfg_we(cfg_we), .cfg_bank(cfg_bank), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
      .req_valid(req_valid), .req_ready(req_ready), .req_bank(req_bank), .req_vec(req_vec),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_vec(rsp_vec), .busy(busy),
      .mm_ivector(mm_ivector), .mm_matrix(mm_matrix), .mm_ovector(mm_ovector),
`ifdef MATMUL_SCHED_STATS_EN
      .stat_ops(stat_ops),
`endif
      .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [15:0] e0, e1, e2, e3);
      return {e3, e2, e1, e0};
   endfunction

   function automatic vec_t mat_vec(input logic [15:0][15:0] m, input vec_t v);
      vec_t res;
      logic signed [39:0] acc;
      res = '0;
      for (int r = 0; r < 4; r++) begin
         acc = '0;
         for (int c = 0; c < 4; c++) acc = acc + $signed(m[4*r+c]) * $signed(v[c]);
         res[r] = acc[23:8];
      end
      return res;
   endfunction

   // registered multiplier, one cycle of latency
   always @(posedge clk) mm_ovector <= mat_vec(mm_matrix, mm_ivector);

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req_valid = '0;
      rsp_ready = '0;
      cfg_we = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic do_write(input logic [0:0] b, input logic [3:0] idx, input logic [15:0] d);
      cfg_we = 1'b1;
      cfg_bank = b;
      cfg_idx = idx;
      cfg_data = d;
      tick();
      cfg_we = 1'b0;
   endtask

   // driver: one full transaction on requester r, optionally racing a bank write with the accept
   task automatic do_op(input int r, input logic [0:0] bank, input vec_t vec, input vec_t exp,
                        input string name, input bit race = 1'b0,
                        input logic [3:0] widx = 4'd0, input logic [15:0] wdata = 16'd0);
      logic [NREQ-1:0] oh;
      int n;
      oh = '0;
      oh[r] = 1'b1;
      req_valid = '0;
      req_valid[r] = 1'b1;
      req_bank[r] = bank;
      req_vec[r] = vec;
      rsp_ready = '0;
      #1;
      n = 0;
      while (req_ready[r] !== 1'b1 && n < 20) begin
         tick();
         #1;
         n++;
      end
      chk($sformatf("%s_grant", name), req_ready, oh);
      if (req_ready[r] !== 1'b1) begin
         req_valid = '0;
         return;
      end
      if (race) begin
         cfg_we = 1'b1;
         cfg_bank = bank;
         cfg_idx = widx;
         cfg_data = wdata;
      end
      tick();
      cfg_we = 1'b0;
      req_valid = '0;
      #1;
      for (int k = 0; k < LAT; k++) begin
         chk($sformatf("%s_issue", name), {rsp_valid, req_ready, busy}, {2'b00, 2'b00, 1'b1});
         tick();
         #1;
      end
      chk($sformatf("%s_rsp_valid", name), rsp_valid, oh);
      chk($sformatf("%s_rsp_vec", name), rsp_vec, exp);
      chk($sformatf("%s_state_resp", name), state_dbg, 2'd2);
      rsp_ready[r] = 1'b1;
      tick();
      rsp_ready = '0;
      #1;
      chk($sformatf("%s_idle", name), {rsp_valid, busy}, {2'b00, 1'b0});
   endtask

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog act=timeout exp=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      vec_t va, vb;
      int grants, rsps, cyc, last_cyc, g;

      tbl[0]  = '{0, 0, 0, 0, 1, 0, 0, mk(16'h0100, 16'h0200, 16'h0300, 16'h0400), mk(16'h0100, 16'h0200, 16'h0300, 16'h0400)};
      tbl[1]  = '{0, 0, 0, 0, 1, 1, 0, mk(16'hFF00, 16'h0080, 16'h1234, 16'h0000), mk(16'hFF00, 16'h0080, 16'h1234, 16'h0000)};
      tbl[2]  = '{1, 1, 4'd0,  16'h0200, 0, 0, 0, '0, '0};
      tbl[3]  = '{1, 1, 4'd5,  16'h0200, 0, 0, 0, '0, '0};
      tbl[4]  = '{1, 1, 4'd10, 16'h0200, 0, 0, 0, '0, '0};
      tbl[5]  = '{1, 1, 4'd15, 16'h0200, 0, 0, 0, '0, '0};
      tbl[6]  = '{0, 0, 0, 0, 1, 1, 1, mk(16'h0100, 16'h0200, 16'h0300, 16'h0400), mk(16'h0200, 16'h0400, 16'h0600, 16'h0800)};
      tbl[7]  = '{0, 0, 0, 0, 1, 0, 1, mk(16'h0080, 16'hFF00, 16'h0001, 16'h7F00), mk(16'h0100, 16'hFE00, 16'h0002, 16'hFE00)};
      tbl[8]  = '{1, 0, 4'd1, 16'h0100, 1, 0, 0, mk(16'h0100, 16'h0200, 16'h0300, 16'h0400), mk(16'h0300, 16'h0200, 16'h0300, 16'h0400)};
      tbl[9]  = '{1, 1, 4'd4, 16'hFF00, 0, 0, 0, '0, '0};
      tbl[10] = '{0, 0, 0, 0, 1, 0, 1, mk(16'h0100, 16'h0100, 16'h0100, 16'h0100), mk(16'h0200, 16'h0100, 16'h0200, 16'h0200)};

      // reset state
      do_reset();
      #1;
      chk("rst_req_ready", req_ready, 2'b00);
      chk("rst_rsp_valid", rsp_valid, 2'b00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_rsp_vec", rsp_vec, 64'd0);
      chk("rst_mm_ivector", mm_ivector, 64'd0);
      chk("rst_mm_matrix", mm_matrix, 256'd0);
      chk("rst_state", state_dbg, 2'd0);

      // table-driven ops and config writes
      for (int i = 0; i < 11; i++) begin
         if (tbl[i].wr_en) do_write(tbl[i].wr_bank, tbl[i].wr_idx, tbl[i].wr_data);
         if (tbl[i].op_en) do_op(tbl[i].r, tbl[i].bank, tbl[i].vec, tbl[i].exp, $sformatf("v%0d", i));
      end

      // fairness with both requesters held valid, starting from reset
      do_reset();
      va = mk(16'h0101, 16'h0202, 16'h0303, 16'h0404);
      vb = mk(16'h0A00, 16'h0B00, 16'h0C00, 16'h0D00);
      req_bank = '0;
      req_vec[0] = va;
      req_vec[1] = vb;
      req_valid = 2'b11;
      rsp_ready = 2'b11;
      exp_q = '{64'd0, 64'd1, 64'd0, 64'd1};
      rsp_q = '{64'd0, 64'd1, 64'd0, 64'd1};
      grants = 0;
      rsps = 0;
      cyc = 0;
      last_cyc = -1;
      while (rsps < 4 && cyc < 40) begin
         #1;
         if (req_ready != 2'b00 && exp_q.size() > 0) begin
            g = (req_ready == 2'b10) ? 1 : 0;
            chk("fair_order", g, exp_q.pop_front());
            if (last_cyc >= 0) chk("fair_spacing", cyc - last_cyc, LAT + 2);
            last_cyc = cyc;
            grants++;
         end
         if (rsp_valid != 2'b00 && rsp_q.size() > 0) begin
            g = int'(rsp_q.pop_front());
            chk("fair_rsp_valid", rsp_valid, (g == 1) ? 2'b10 : 2'b01);
            chk("fair_rsp_vec", rsp_vec, (g == 1) ? vb : va);
            rsps++;
         end
         tick();
         if (grants == 4) req_valid = '0;
         cyc++;
      end
      chk("fair_grants", grants, 4);
      chk("fair_rsps", rsps, 4);
      rsp_ready = '0;
      #1;
      chk("fair_done_idle", busy, 1'b0);

      // backpressure: response held for 5 cycles while the other requester waits
      req_valid = 2'b01;
      req_vec[0] = va;
      #1;
      chk("bp_grant", req_ready, 2'b01);
      tick();
      req_valid = 2'b10;
      tick();
      #1;
      for (int k = 0; k < 5; k++) begin
         chk("bp_rsp_valid", rsp_valid, 2'b01);
         chk("bp_rsp_vec", rsp_vec, va);
         chk("bp_req_ready", req_ready, 2'b00);
         chk("bp_busy", busy, 1'b1);
         tick();
         #1;
      end
      rsp_ready = 2'b01;
      req_valid = 2'b00;
      tick();
      rsp_ready = '0;
      #1;
      chk("bp_release", {busy, req_ready, state_dbg}, {1'b0, 2'b00, 2'd0});
      tick();
      #1;
      chk("bp_dropped_not_granted", {busy, rsp_valid}, {1'b0, 2'b00});

      // write/grant race on bank0[0]
      do_op(0, 0, mk(16'h0100, 0, 0, 0), mk(16'h0100, 0, 0, 0), "race_old", 1'b1, 4'd0, 16'h0300);
      do_op(0, 0, mk(16'h0100, 0, 0, 0), mk(16'h0300, 0, 0, 0), "race_new");

      // reset during RESP drops the response
      req_valid = 2'b10;
      req_bank[1] = 1'b0;
      req_vec[1] = vb;
      #1;
      chk("abort_grant", req_ready, 2'b10);
      tick();
      req_valid = '0;
      tick();
      #1;
      chk("abort_in_resp", rsp_valid, 2'b10);
      reset = 1'b1;
      tick();
      #1;
      chk("abort_req_ready", req_ready, 2'b00);
      chk("abort_rsp_valid", rsp_valid, 2'b00);
      chk("abort_busy", busy, 1'b0);
      chk("abort_rsp_vec", rsp_vec, 64'd0);
      chk("abort_mm", {mm_ivector, mm_matrix}, 320'd0);
      reset = 1'b0;
      for (int k = 0; k < 2; k++) begin
         tick();
         #1;
         chk("abort_no_rsp", {rsp_valid, busy}, {2'b00, 1'b0});
      end
      do_op(0, 0, mk(16'h0100, 16'h0200, 16'h0300, 16'h0400), mk(16'h0100, 16'h0200, 16'h0300, 16'h0400), "post_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
